gpio_endpoint: RTL and testbench

//  Synthesizable DUT-side GPIO endpoint, the far end of the GPIO agent's pins.
//  It synchronizes and edge-detects pin_in, which the agent drives.

---
 rtl/gpio_endpoint_pkg.sv | 14 +
 rtl/gpio_evt_fifo.sv | 57 +++++
 rtl/gpio_endpoint.sv | 140 ++++++++++++++
 tb/tb_gpio_endpoint.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_endpoint_pkg.sv
// Shared types for the GPIO endpoint: pin_out write opcodes
// and the arming delay after reset release.
package gpio_endpoint_pkg;

    typedef enum logic [1:0] {
        WRITE  = 2'd0,
        SET    = 2'd1,
        CLR    = 2'd2,
        TOGGLE = 2'd3
    } wr_op_e;

    localparam int ARM_CYCLES = 3;

endpackage

// File: rtl/gpio_evt_fifo.sv
// Show-ahead event FIFO with sticky overflow flag.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module gpio_evt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;
    logic             drop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && full && !pop_ok;

    // Gate the head so evt_* read as zero while nothing is queued.
    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (drop)         ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/gpio_endpoint.sv
// GPIO endpoint: pin sync, edge events with timestamps, pin_out commands.
// Define GPIO_DEBOUNCE_EN to add a per-pin debounce filter.
module gpio_endpoint
    import gpio_endpoint_pkg::*;
#(
    parameter int PIN_IN_NUM      = 32,
    parameter int PIN_OUT_NUM     = 32,
    parameter int FIFO_DEPTH      = 8,
    parameter int TS_W            = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIN_IN_NUM-1:0]  pin_in,
    output logic [PIN_OUT_NUM-1:0] pin_out,
    input  logic [PIN_IN_NUM-1:0]  rise_en,
    input  logic [PIN_IN_NUM-1:0]  fall_en,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [PIN_IN_NUM-1:0]  evt_pins,
    output logic [PIN_IN_NUM-1:0]  evt_mask,
    output logic [TS_W-1:0]        evt_ts,
    output logic                   ovf,
    input  logic                   ovf_clr,
    input  logic                   wr_valid,
    input  logic [1:0]             wr_op,
    input  logic [PIN_OUT_NUM-1:0] wr_data
);

`ifdef GPIO_DEBOUNCE_EN
    localparam int DB_EN = 1;
`else
    localparam int DB_EN = 0;
`endif

    // Arming also has to cover the debounce filter settling.
    localparam int ARM_LIMIT = ARM_CYCLES + DB_EN * (DEBOUNCE_CYCLES + 1);
    localparam int AC_W      = $clog2(ARM_LIMIT + 1);
    localparam int EW        = 2 * PIN_IN_NUM + TS_W;

    logic [PIN_IN_NUM-1:0] sync1;
    logic [PIN_IN_NUM-1:0] sync2;
    logic [PIN_IN_NUM-1:0] filt;
    logic [PIN_IN_NUM-1:0] prev;
    logic [PIN_IN_NUM-1:0] trig;
    logic [AC_W-1:0]       arm_cnt;
    logic                  armed;
    logic [TS_W-1:0]       ts;
    logic [TS_W-1:0]       ts_next;
    logic [EW-1:0]         fifo_out;
    logic                  fifo_empty;
    logic                  unused_full;
    wr_op_e                op;

    assign armed   = (arm_cnt == AC_W'(ARM_LIMIT));
    assign ts_next = ts + 1'b1;
    assign op      = wr_op_e'(wr_op);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            prev    <= '0;
            ts      <= '0;
            arm_cnt <= '0;
        end else begin
            sync1 <= pin_in;
            sync2 <= sync1;
            prev  <= filt;
            ts    <= ts_next;
            if (!armed) arm_cnt <= arm_cnt + 1'b1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0]         db_cnt [PIN_IN_NUM];
    logic [PIN_IN_NUM-1:0] filt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= '0;
            for (int i = 0; i < PIN_IN_NUM; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < PIN_IN_NUM; i++) begin
                if (sync2[i] == filt_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    filt_q[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync2;
`endif

    assign trig = armed ? ((filt & ~prev & rise_en) |
                           (~filt & prev & fall_en)) : '0;

    // The stored stamp is the value ts takes on the capturing edge.
    gpio_evt_fifo #(
        .WIDTH(EW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (|trig),
        .din    ({filt, trig, ts_next}),
        .pop    (evt_ready),
        .ovf_clr(ovf_clr),
        .dout   (fifo_out),
        .full   (unused_full),
        .empty  (fifo_empty),
        .ovf    (ovf)
    );

    assign evt_valid = !fifo_empty;
    assign {evt_pins, evt_mask, evt_ts} = fifo_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pin_out <= '0;
        end else if (wr_valid) begin
            unique case (op)
                WRITE:  pin_out <= wr_data;
                SET:    pin_out <= pin_out | wr_data;
                CLR:    pin_out <= pin_out & ~wr_data;
                TOGGLE: pin_out <= pin_out ^ wr_data;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_endpoint.sv
// Self-checking bench for gpio_endpoint against a pin-history event model.
// Build with GPIO_DEBOUNCE_EN defined to exercise the debounce filter.
module tb_gpio_endpoint;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pin_in = '0;
    logic [31:0] pin_out;
    logic [31:0] rise_en = '0;
    logic [31:0] fall_en = '0;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [31:0] evt_pins;
    logic [31:0] evt_mask;
    logic [15:0] evt_ts;
    logic        ovf;
    logic        ovf_clr = 1'b0;
    logic        wr_valid = 1'b0;
    logic [1:0]  wr_op = '0;
    logic [31:0] wr_data = '0;

    int checks = 0;
    int failures = 0;

    gpio_endpoint dut (
        .clk      (clk),
        .rst      (rst),
        .pin_in   (pin_in),
        .pin_out  (pin_out),
        .rise_en  (rise_en),
        .fall_en  (fall_en),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_pins (evt_pins),
        .evt_mask (evt_mask),
        .evt_ts   (evt_ts),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
        .wr_valid (wr_valid),
        .wr_op    (wr_op),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pins;
        logic [31:0] mask;
        logic [15:0] ts;
    } ev_t;

    // Model: pin samples taken at the last three edges, an event queue,
    // the overflow flag, the pin_out image and the edge count since release.
    ev_t         q[$];
    logic [31:0] s1, s2, s3;
    logic        m_ovf;
    logic [31:0] m_pout;
    int unsigned e;

    wire [81:0] got_evt = {evt_valid, evt_pins, evt_mask, evt_ts, ovf};

    function automatic logic [81:0] exp_evt();
        if (q.size() == 0) return {1'b0, 80'b0, m_ovf};
        return {1'b1, q[0].pins, q[0].mask, q[0].ts, m_ovf};
    endfunction

    task automatic model_reset();
        e = 0;
        s1 = '0;
        s2 = '0;
        s3 = '0;
        q.delete();
        m_ovf = 1'b0;
        m_pout = '0;
    endtask

    task automatic tick();
        logic [31:0] f, pr, tg;
        ev_t ev;
        bit drop;
        e++;
        f = s2;
        pr = s3;
        tg = (f & ~pr & rise_en) | (~f & pr & fall_en);
        if (evt_ready && q.size() > 0) void'(q.pop_front());
        drop = 0;
        if (e >= 4 && tg != 0) begin
            if (q.size() < 8) begin
                ev.pins = f;
                ev.mask = tg;
                ev.ts = 16'(e);
                q.push_back(ev);
            end else begin
                drop = 1;
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        if (wr_valid) begin
            case (wr_op)
                2'd0: m_pout = wr_data;
                2'd1: m_pout = m_pout | wr_data;
                2'd2: m_pout = m_pout & ~wr_data;
                default: m_pout = m_pout ^ wr_data;
            endcase
        end
        s3 = s2;
        s2 = s1;
        s1 = pin_in;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pin_in = 32'hA5A5_5A5A;
        wr_valid = 1'b1;
        wr_data = 32'hFFFF_FFFF;
        evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pin_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_pin_out got=%h exp=0", pin_out);
        end
        checks++;
        if (got_evt !== 82'h0) begin
            failures++;
            $display("FAIL reset_evt got=%h exp=0", got_evt);
        end
        wr_valid = 1'b0;
        wr_data = '0;
        evt_ready = 1'b0;
        pin_in = '0;
        do_reset();
    endtask

    task automatic test_single_rise();
        do_reset();
        rise_en = 32'h1;
        fall_en = 32'h0;
        repeat (5) tick();
        pin_in = 32'h1;
        tick();
        tick();
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL rise_early got=%b exp=0", evt_valid);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_mask !== 32'h1 || evt_pins[0] !== 1'b1) begin
            failures++;
            $display("FAIL rise_evt got=%b/%h/%h exp=1/1/bit0", evt_valid, evt_mask, evt_pins);
        end
        checks++;
        if (evt_ts !== 16'(e)) begin
            failures++;
            $display("FAIL rise_ts got=%0d exp=%0d", evt_ts, 16'(e));
        end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL rise_pop got=%b exp=0", evt_valid);
        end
    endtask

    task automatic test_reset_high();
        int bad = 0;
        pin_in = '1;
        rise_en = '1;
        fall_en = '0;
        do_reset();
        repeat (8) begin
            tick();
            if (evt_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL high_at_reset got=%0d spurious exp=0", bad);
        end
        rise_en = '0;
        fall_en = 32'h20;
        pin_in[5] = 1'b0;
        repeat (3) tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_mask !== 32'h20 || evt_pins[5] !== 1'b0) begin
            failures++;
            $display("FAIL fall_evt got=%b/%h/%h exp=1/20/bit5=0", evt_valid, evt_mask, evt_pins);
        end
        checks++;
        if (got_evt !== exp_evt()) begin
            failures++;
            $display("FAIL fall_model got=%h exp=%h", got_evt, exp_evt());
        end
        pin_in = '0;
        fall_en = '0;
    endtask

    task automatic test_overflow();
        int n = 0;
        int ts_bad = 0;
        logic [15:0] last = '0;
        do_reset();
        rise_en = 32'h1;
        fall_en = 32'h1;
        repeat (4) tick();
        for (int i = 0; i < 9; i++) begin
            pin_in[0] = ~pin_in[0];
            tick();
            tick();
        end
        repeat (3) tick();
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set got=%b exp=1", ovf);
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (!evt_valid) break;
            checks++;
            if (got_evt !== exp_evt()) begin
                failures++;
                $display("FAIL drain_order got=%h exp=%h", got_evt, exp_evt());
            end
            if (evt_ts <= last) ts_bad++;
            last = evt_ts;
            n++;
            tick();
        end
        evt_ready = 1'b0;
        checks++;
        if (n != 8 || ts_bad != 0) begin
            failures++;
            $display("FAIL drain_count got=%0d/%0d exp=8/0", n, ts_bad);
        end
    endtask

    task automatic test_full_pop_push();
        int n = 0;
        int unsigned push_e;
        logic [15:0] last = '0;
        do_reset();
        rise_en = 32'h1;
        fall_en = 32'h1;
        pin_in = '0;
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            pin_in[0] = ~pin_in[0];
            tick();
            tick();
        end
        repeat (3) tick();
        pin_in[0] = ~pin_in[0];
        tick();
        tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        push_e = e;
        checks++;
        if (ovf !== 1'b0 || got_evt !== exp_evt()) begin
            failures++;
            $display("FAIL full_pop_push got=%h exp=%h", got_evt, exp_evt());
        end
        pin_in[0] = ~pin_in[0];
        tick();
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_clr_vs_drop got=%b exp=1", ovf);
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (!evt_valid) break;
            last = evt_ts;
            n++;
            tick();
        end
        evt_ready = 1'b0;
        checks++;
        if (n != 8 || last !== 16'(push_e)) begin
            failures++;
            $display("FAIL full_drain got=%0d/%0d exp=8/%0d", n, last, 16'(push_e));
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got=%b exp=0", ovf);
        end
    endtask

    task automatic test_pin_out();
        logic [1:0]  ops [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [31:0] dat [4] = '{32'hF0, 32'h0F, 32'h30, 32'hFF};
        logic [31:0] exp [4] = '{32'hF0, 32'hFF, 32'hCF, 32'h30};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_op = ops[i];
            wr_data = dat[i];
            tick();
            checks++;
            if (pin_out !== exp[i]) begin
                failures++;
                $display("FAIL pin_out_seq%0d got=%h exp=%h", i, pin_out, exp[i]);
            end
        end
        for (int i = 0; i < 24; i++) begin
            wr_valid = 1'($urandom);
            wr_op = 2'($urandom);
            wr_data = $urandom;
            tick();
            checks++;
            if (pin_out !== m_pout) begin
                failures++;
                $display("FAIL pin_out_rand got=%h exp=%h", pin_out, m_pout);
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            pin_in = pin_in ^ ($urandom & $urandom & $urandom);
            rise_en = $urandom;
            fall_en = $urandom;
            evt_ready = (i < 200) ? ($urandom_range(0, 3) == 0)
                                  : ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (got_evt !== exp_evt()) begin
                failures++;
                $display("FAIL random_evt cyc=%0d got=%h exp=%h", i, got_evt, exp_evt());
            end
        end
        evt_ready = 1'b0;
        ovf_clr = 1'b0;
        pin_in = '0;
    endtask

    task automatic test_rst_mid();
        int bad = 0;
        do_reset();
        rise_en = 32'h1;
        fall_en = 32'h0;
        pin_in = '0;
        repeat (10) tick();
        pin_in[0] = 1'b1;
        repeat (3) tick();
        checks++;
        if (evt_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre got=%b exp=1", evt_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (evt_valid !== 1'b0 || evt_mask !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_async got=%b/%h exp=0/0", evt_valid, evt_mask);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (12) begin
            tick();
            if (evt_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rst_mid_after got=%0d spurious exp=0", bad);
        end
        pin_in = '0;
    endtask

`ifdef GPIO_DEBOUNCE_EN
    task automatic test_debounce();
        do_reset();
        rise_en = 32'h1;
        fall_en = 32'h0;
        pin_in = '0;
        repeat (12) tick();
        pin_in[0] = 1'b1;
        repeat (3) tick();
        pin_in[0] = 1'b0;
        repeat (15) tick();
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL db_glitch got=%b exp=0", evt_valid);
        end
        pin_in[0] = 1'b1;
        repeat (5) tick();
        pin_in[0] = 1'b0;
        repeat (15) tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_mask !== 32'h1 || evt_pins[0] !== 1'b1) begin
            failures++;
            $display("FAIL db_level got=%b/%h/%h exp=1/1/bit0", evt_valid, evt_mask, evt_pins);
        end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL db_single got=%b exp=0", evt_valid);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
`ifdef GPIO_DEBOUNCE_EN
        test_debounce();
`else
        test_single_rise();
        test_reset_high();
        test_overflow();
        test_full_pop_push();
        test_random();
`endif
        test_pin_out();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
